// File: rtl/rx_packet_dispatch.sv
// rx_packet_dispatch
//   Receive-side classifier for decoded 8b10b symbols. Control commas become
//   one-cycle write strobes toward the TX arbitration queues. START/DATA/END
//   framing is tracked by a state machine. Payload flits are staged in a
//   commit/rollback FIFO, so downstream only ever sees complete, well-formed
//   packets.
// Ports
//   CLK, nRST             clock; asynchronous active-low reset
//   sym_valid             decoded symbol present this cycle
//   sym_is_comma          1 = comma (sym_comma_sel / sym_header), 0 = data flit
//   sym_comma_sel         comma type
//   sym_header            header byte carried with a comma
//   sym_data              data flit
//   flit_out              head of committed FIFO data (0 when nothing committed)
//   flit_out_valid        committed flit available
//   flit_out_ready        downstream pop
//   pkt_done, pkt_err     one-cycle pulses: packet committed / packet discarded
//   *_write               TX queue strobes, one cycle after the comma is accepted
//   rx_header             header qualifying any strobe in the same cycle
//   fifo_count            number of committed, unread flits

package phy_types_pkg;
  typedef enum logic [3:0] {
    COMMA_START          = 4'd0,
    COMMA_END            = 4'd1,
    COMMA_GRTCRED0       = 4'd2,
    COMMA_GRTCRED1       = 4'd3,
    COMMA_BAUD           = 4'd4,
    COMMA_REQ_CTRL_BAUD  = 4'd5,
    COMMA_GRT_CTRL_BAUD  = 4'd6,
    COMMA_NACK_CTRL_BAUD = 4'd7,
    COMMA_ACK            = 4'd8
  } comma_sel_t;
endpackage

module rx_packet_dispatch
  import phy_types_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FLIT_W     = 32
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          sym_valid,
  input  logic                          sym_is_comma,
  input  comma_sel_t                    sym_comma_sel,
  input  logic [7:0]                    sym_header,
  input  logic [FLIT_W-1:0]             sym_data,
  output logic [FLIT_W-1:0]             flit_out,
  output logic                          flit_out_valid,
  input  logic                          flit_out_ready,
  output logic                          pkt_done,
  output logic                          pkt_err,
  output logic                          ack_write,
  output logic                          nack_baud_write,
  output logic                          grtcred0_write,
  output logic                          grtcred1_write,
  output logic                          baud_comma_write,
  output logic                          req_ctrl_comma_write,
  output logic                          grt_ctrl_comma_write,
  output logic [7:0]                    rx_header,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, WAIT_END, DROP} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       wr_ptr, commit_ptr, rd_ptr;
  logic [8:0]             len, cnt;
  logic [FLIT_W-1:0]      mem [FIFO_DEPTH];

  logic                   is_data, full, push, pop;
  logic [8:0]             first_len;

  // Expected packet length is carried in the low 9 bits of the first flit.
  assign first_len = sym_data[8:0];

  assign is_data = sym_valid && !sym_is_comma;
  // Occupancy includes speculative flits and is taken before this cycle's pop.
  assign full    = (wr_ptr - rd_ptr) == DEPTH_P;
  assign push    = is_data && (state == HEADER || state == PAYLOAD) && !full;

  assign flit_out_valid = (commit_ptr != rd_ptr);
  assign pop            = flit_out_valid && flit_out_ready;
  assign flit_out       = flit_out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign fifo_count     = commit_ptr - rd_ptr;

  // ---- stage boundary: flit storage (data path, not reset) ----
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sym_data;
  end

  // ---- stage boundary: framing FSM, pointers and registered strobes ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state                <= IDLE;
      wr_ptr               <= '0;
      commit_ptr           <= '0;
      rd_ptr               <= '0;
      len                  <= '0;
      cnt                  <= '0;
      pkt_done             <= 1'b0;
      pkt_err              <= 1'b0;
      ack_write            <= 1'b0;
      nack_baud_write      <= 1'b0;
      grtcred0_write       <= 1'b0;
      grtcred1_write       <= 1'b0;
      baud_comma_write     <= 1'b0;
      req_ctrl_comma_write <= 1'b0;
      grt_ctrl_comma_write <= 1'b0;
      rx_header            <= '0;
    end else begin
      pkt_done             <= 1'b0;
      pkt_err              <= 1'b0;
      ack_write            <= 1'b0;
      nack_baud_write      <= 1'b0;
      grtcred0_write       <= 1'b0;
      grtcred1_write       <= 1'b0;
      baud_comma_write     <= 1'b0;
      req_ctrl_comma_write <= 1'b0;
      grt_ctrl_comma_write <= 1'b0;
      rx_header            <= '0;

      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (sym_valid && sym_is_comma) begin
        unique case (sym_comma_sel)
          COMMA_GRTCRED0:       begin grtcred0_write       <= 1'b1; rx_header <= sym_header; end
          COMMA_GRTCRED1:       begin grtcred1_write       <= 1'b1; rx_header <= sym_header; end
          COMMA_BAUD:           begin baud_comma_write     <= 1'b1; rx_header <= sym_header; end
          COMMA_REQ_CTRL_BAUD:  begin req_ctrl_comma_write <= 1'b1; rx_header <= sym_header; end
          COMMA_GRT_CTRL_BAUD:  begin grt_ctrl_comma_write <= 1'b1; rx_header <= sym_header; end
          COMMA_NACK_CTRL_BAUD: begin nack_baud_write      <= 1'b1; rx_header <= sym_header; end
          COMMA_ACK:            begin ack_write            <= 1'b1; rx_header <= sym_header; end
          COMMA_START: begin
            // A START inside a packet abandons it; the new packet begins at once.
            if (state != IDLE) begin
              wr_ptr          <= commit_ptr;
              pkt_err         <= 1'b1;
              nack_baud_write <= 1'b1;
            end
            state <= HEADER;
          end
          COMMA_END: begin
            rx_header <= sym_header;
            if (state == WAIT_END) begin
              commit_ptr <= wr_ptr;
              ack_write  <= 1'b1;
              pkt_done   <= 1'b1;
            end else begin
              wr_ptr          <= commit_ptr;
              pkt_err         <= 1'b1;
              nack_baud_write <= 1'b1;
            end
            state <= IDLE;
          end
          default: ;
        endcase
      end else if (is_data) begin
        unique case (state)
          IDLE: pkt_err <= 1'b1;
          HEADER: begin
            if (full) begin
              wr_ptr <= commit_ptr;
              state  <= DROP;
            end else begin
              len   <= first_len;
              cnt   <= 9'd1;
              state <= (first_len == 9'd1) ? WAIT_END : PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (full) begin
              wr_ptr <= commit_ptr;
              state  <= DROP;
            end else begin
              cnt <= cnt + 9'd1;
              if (cnt + 9'd1 == len) state <= WAIT_END;
            end
          end
          WAIT_END: begin
            // Too many flits: drop the packet, the nack goes out with END.
            wr_ptr <= commit_ptr;
            state  <= DROP;
          end
          DROP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_dispatch.sv
// tb_rx_packet_dispatch
//   Scoreboard bench for rx_packet_dispatch. Flits of packets that should
//   commit are queued when their END is driven; the queue is popped and
//   compared whenever the DUT presents a flit with ready high.
module tb_rx_packet_dispatch;
  import phy_types_pkg::*;

  localparam int FIFO_DEPTH = 16;
  localparam int FLIT_W     = 32;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              sym_valid, sym_is_comma;
  comma_sel_t        sym_comma_sel;
  logic [7:0]        sym_header;
  logic [FLIT_W-1:0] sym_data;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid, flit_out_ready;
  logic              pkt_done, pkt_err;
  logic              ack_write, nack_baud_write, grtcred0_write, grtcred1_write;
  logic              baud_comma_write, req_ctrl_comma_write, grt_ctrl_comma_write;
  logic [7:0]        rx_header;
  logic [4:0]        fifo_count;
  logic [6:0]        strb;

  rx_packet_dispatch #(.FIFO_DEPTH(FIFO_DEPTH), .FLIT_W(FLIT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .sym_valid(sym_valid), .sym_is_comma(sym_is_comma),
    .sym_comma_sel(sym_comma_sel), .sym_header(sym_header), .sym_data(sym_data),
    .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
    .pkt_done(pkt_done), .pkt_err(pkt_err),
    .ack_write(ack_write), .nack_baud_write(nack_baud_write),
    .grtcred0_write(grtcred0_write), .grtcred1_write(grtcred1_write),
    .baud_comma_write(baud_comma_write), .req_ctrl_comma_write(req_ctrl_comma_write),
    .grt_ctrl_comma_write(grt_ctrl_comma_write),
    .rx_header(rx_header), .fifo_count(fifo_count)
  );

  // {ack, nack, grtcred0, grtcred1, baud, req_ctrl, grt_ctrl}
  assign strb = {ack_write, nack_baud_write, grtcred0_write, grtcred1_write,
                 baud_comma_write, req_ctrl_comma_write, grt_ctrl_comma_write};

  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_ACK  = 7'b1000000;
  localparam logic [6:0] S_NACK = 7'b0100000;

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [FLIT_W-1:0] sb [$];
  logic [FLIT_W-1:0] cur [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  // Consumer side: every pop is compared against the scoreboard head.
  always @(negedge CLK) begin
    if (nRST && flit_out_valid && flit_out_ready) begin
      chk("pop_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) chk("pop_data", {32'd0, flit_out}, {32'd0, sb.pop_front()});
    end
  end

  task automatic drive_sym(input logic comma, input comma_sel_t sel,
                           input logic [7:0] hdr, input logic [FLIT_W-1:0] d);
    sym_valid = 1'b1; sym_is_comma = comma; sym_comma_sel = sel;
    sym_header = hdr; sym_data = d;
    @(posedge CLK); #1;
    sym_valid = 1'b0; sym_is_comma = 1'b0; sym_data = '0; sym_header = '0;
  endtask

  task automatic send_comma(input comma_sel_t sel, input logic [7:0] hdr);
    drive_sym(1'b1, sel, hdr, '0);
  endtask

  // First flit of a packet carries the length in bits [8:0].
  task automatic send_flit(input logic first, input int len);
    logic [FLIT_W-1:0] d;
    d = $urandom;
    if (first) d[8:0] = len[8:0];
    cur.push_back(d);
    drive_sym(1'b0, COMMA_START, 8'h00, d);
  endtask

  task automatic send_body(input int len, input int n);
    for (int i = 0; i < n; i++) send_flit(i == 0, len);
  endtask

  task automatic commit_cur();
    while (cur.size() != 0) sb.push_back(cur.pop_front());
  endtask

  task automatic expect_out(input string tag, input logic [6:0] s, input logic done,
                            input logic err, input logic [7:0] hdr);
    chk({tag, "_strobes"}, {57'd0, strb}, {57'd0, s});
    chk({tag, "_done"}, {63'd0, pkt_done}, {63'd0, done});
    chk({tag, "_err"}, {63'd0, pkt_err}, {63'd0, err});
    chk({tag, "_hdr"}, {56'd0, rx_header}, {56'd0, hdr});
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic drain(input string tag);
    flit_out_ready = 1'b1;
    for (int i = 0; i < 64 && fifo_count != 0; i++) idle_cycle();
    flit_out_ready = 1'b0;
    chk({tag, "_drained"}, {59'd0, fifo_count}, 64'd0);
    chk({tag, "_sb_empty"}, sb.size(), 64'd0);
  endtask

  comma_sel_t  ctl_sel [7] = '{COMMA_GRTCRED0, COMMA_GRTCRED1, COMMA_BAUD, COMMA_REQ_CTRL_BAUD,
                              COMMA_GRT_CTRL_BAUD, COMMA_NACK_CTRL_BAUD, COMMA_ACK};
  logic [6:0]  ctl_exp [7] = '{7'b0010000, 7'b0001000, 7'b0000100, 7'b0000010,
                              7'b0000001, 7'b0100000, 7'b1000000};

  initial begin
    nRST = 1'b0; flit_out_ready = 1'b0;
    sym_valid = 1'b0; sym_is_comma = 1'b0; sym_comma_sel = COMMA_START;
    sym_header = '0; sym_data = '0;
    repeat (3) @(negedge CLK);
    expect_out("reset", S_NONE, 1'b0, 1'b0, 8'h00);
    chk("reset_count", {59'd0, fifo_count}, 64'd0);
    chk("reset_valid", {63'd0, flit_out_valid}, 64'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // Control commas are forwarded one-for-one with their header.
    for (int i = 0; i < 7; i++) begin
      send_comma(ctl_sel[i], 8'(8'h10 + i));
      expect_out("ctl_comma", ctl_exp[i], 1'b0, 1'b0, 8'(8'h10 + i));
    end

    // 1: three-flit packet commits on END.
    send_comma(COMMA_START, 8'h01);
    expect_out("t1_start", S_NONE, 1'b0, 1'b0, 8'h00);
    send_body(3, 3);
    chk("t1_uncommitted", {59'd0, fifo_count}, 64'd0);
    send_comma(COMMA_END, 8'h5A); commit_cur();
    expect_out("t1_end", S_ACK, 1'b1, 1'b0, 8'h5A);
    chk("t1_count", {59'd0, fifo_count}, 64'd3);
    chk("t1_valid", {63'd0, flit_out_valid}, 64'd1);
    idle_cycle();
    chk("t1_done_pulse", {63'd0, pkt_done}, 64'd0);
    drain("t1");

    // 2: GRTCRED1 inside a four-flit packet.
    send_comma(COMMA_START, 8'h02);
    send_body(4, 2);
    send_comma(COMMA_GRTCRED1, 8'h33);
    expect_out("t2_comma", 7'b0001000, 1'b0, 1'b0, 8'h33);
    send_flit(1'b0, 0); send_flit(1'b0, 0);
    send_comma(COMMA_END, 8'h44); commit_cur();
    expect_out("t2_end", S_ACK, 1'b1, 1'b0, 8'h44);
    chk("t2_count", {59'd0, fifo_count}, 64'd4);
    drain("t2");

    // 3: short packet is discarded.
    send_comma(COMMA_START, 8'h03);
    send_body(4, 2);
    send_comma(COMMA_END, 8'h77); cur.delete();
    expect_out("t3_end", S_NACK, 1'b0, 1'b1, 8'h77);
    chk("t3_count", {59'd0, fifo_count}, 64'd0);
    chk("t3_valid", {63'd0, flit_out_valid}, 64'd0);

    // 4: overflow with 10 committed flits unread.
    send_comma(COMMA_START, 8'h04);
    send_body(10, 10);
    send_comma(COMMA_END, 8'h40); commit_cur();
    chk("t4_fill", {59'd0, fifo_count}, 64'd10);
    send_comma(COMMA_START, 8'h04);
    send_body(8, 8); cur.delete();
    send_comma(COMMA_END, 8'h66);
    expect_out("t4_end", S_NACK, 1'b0, 1'b1, 8'h66);
    chk("t4_count", {59'd0, fifo_count}, 64'd10);
    drain("t4");

    // 5: FIFO exactly full; commit and pop on the same edge.
    send_comma(COMMA_START, 8'h05);
    send_body(12, 12);
    send_comma(COMMA_END, 8'h50); commit_cur();
    send_comma(COMMA_START, 8'h05);
    send_body(4, 4);
    flit_out_ready = 1'b1;
    send_comma(COMMA_END, 8'h55); commit_cur();
    flit_out_ready = 1'b0;
    expect_out("t5_end", S_ACK, 1'b1, 1'b0, 8'h55);
    chk("t5_count", {59'd0, fifo_count}, 64'd15);
    chk("t5_sb_count", sb.size(), 64'd15);
    drain("t5");

    // 7: framing errors outside packets and START restart.
    drive_sym(1'b0, COMMA_START, 8'h00, 32'h1);
    expect_out("t7_idle_data", S_NONE, 1'b0, 1'b1, 8'h00);
    send_comma(COMMA_END, 8'h12);
    expect_out("t7_idle_end", S_NACK, 1'b0, 1'b1, 8'h12);
    send_comma(COMMA_START, 8'h07);
    send_body(3, 1);
    send_comma(COMMA_START, 8'h08); cur.delete();
    expect_out("t7_restart", S_NACK, 1'b0, 1'b1, 8'h00);
    send_body(1, 1);
    send_comma(COMMA_END, 8'h34); commit_cur();
    expect_out("t7_end", S_ACK, 1'b1, 1'b0, 8'h34);
    chk("t7_count", {59'd0, fifo_count}, 64'd1);

    // 6: asynchronous reset inside PAYLOAD discards everything.
    send_comma(COMMA_START, 8'h06);
    send_body(5, 2);
    #3 nRST = 1'b0;
    sb.delete(); cur.delete();
    #1;
    expect_out("t6_rst", S_NONE, 1'b0, 1'b0, 8'h00);
    chk("t6_rst_count", {59'd0, fifo_count}, 64'd0);
    chk("t6_rst_valid", {63'd0, flit_out_valid}, 64'd0);
    chk("t6_rst_flit", {32'd0, flit_out}, 64'd0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    send_comma(COMMA_START, 8'h06);
    send_body(1, 1);
    send_comma(COMMA_END, 8'h21); commit_cur();
    expect_out("t6_end", S_ACK, 1'b1, 1'b0, 8'h21);
    chk("t6_count", {59'd0, fifo_count}, 64'd1);
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
